// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart transmitter among NUM_REQ byte-stream requesters.
//
// Round-robin arbitration with packet locking. The owner keeps the transmitter until its
// byte flagged last has finished shifting out. Two watchdogs abort a stuck transfer:
// the uart never raising tx_busy after wr_en, or the owner stalling mid-packet.
//
// Ports:
//   clk_50m       in   system clock
//   rst           in   asynchronous active-high reset
//   req_valid     in   [NUM_REQ]   per-requester byte valid
//   req_data      in   [8*NUM_REQ] byte for requester i at [8i+7:8i]
//   req_last      in   [NUM_REQ]   byte is the final byte of its packet
//   req_ready     out  [NUM_REQ]   byte accepted, one-cycle pulse to the owner only
//   uart_din      out  [8]         byte to the uart, registered and held while shifting
//   uart_wr_en    out  1           registered one-cycle write strobe to the uart
//   uart_tx_busy  in   1           uart is shifting a byte
//   grant         out  [NUM_REQ]   one-hot current owner, 0 when idle
//   lock_active   out  1           packet in progress
//   err_timeout   out  1           one-cycle pulse when either watchdog expires

module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_din,
    output logic                   uart_wr_en,
    input  logic                   uart_tx_busy,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   lock_active,
    output logic                   err_timeout
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned LW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitBusy,
        StWaitDone,
        StHold
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic            last_r;
    logic [BW-1:0]   busy_cnt;
    logic [LW-1:0]   lock_cnt;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   next_ptr;
    logic [7:0]      sel_data;

    // Round-robin search starting at rr_ptr. The loop runs from the farthest candidate
    // down to rr_ptr itself so the nearest valid requester is written last and wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = PW'((int'(rr_ptr) + k) % int'(NUM_REQ));
            if (req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign next_ptr  = PW'((int'(owner) + 1) % int'(NUM_REQ));
    assign sel_data  = req_data[{owner, 3'b000} +: 8];

    // The only combinational output: the accept strobe coincides with the LOAD cycle.
    assign req_ready = (state == StLoad) ? grant : '0;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            rr_ptr      <= '0;
            owner       <= '0;
            last_r      <= 1'b0;
            busy_cnt    <= '0;
            lock_cnt    <= '0;
            uart_din    <= 8'h00;
            uart_wr_en  <= 1'b0;
            grant       <= '0;
            lock_active <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            uart_wr_en  <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pick_valid && !uart_tx_busy) begin
                        owner       <= pick_idx;
                        grant       <= NUM_REQ'(1) << pick_idx;
                        lock_active <= 1'b1;
                        state       <= StLoad;
                    end
                end
                StLoad: begin
                    uart_din   <= sel_data;
                    uart_wr_en <= 1'b1;
                    last_r     <= req_last[owner];
                    busy_cnt   <= '0;
                    state      <= StWaitBusy;
                end
                StWaitBusy: begin
                    // Expires BUSY_TIMEOUT+1 cycles after the wr_en strobe went high.
                    if (uart_tx_busy) begin
                        state <= StWaitDone;
                    end else if (busy_cnt == BW'(BUSY_TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        grant       <= '0;
                        lock_active <= 1'b0;
                        rr_ptr      <= next_ptr;
                        state       <= StIdle;
                    end else begin
                        busy_cnt <= busy_cnt + BW'(1);
                    end
                end
                StWaitDone: begin
                    if (!uart_tx_busy) begin
                        if (last_r) begin
                            grant       <= '0;
                            lock_active <= 1'b0;
                            rr_ptr      <= next_ptr;
                            state       <= StIdle;
                        end else begin
                            lock_cnt <= '0;
                            state    <= StHold;
                        end
                    end
                end
                StHold: begin
                    // Only the owner is looked at; expiry after LOCK_TIMEOUT stalled cycles.
                    if (req_valid[owner]) begin
                        state <= StLoad;
                    end else if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        grant       <= '0;
                        lock_active <= 1'b0;
                        rr_ptr      <= next_ptr;
                        state       <= StIdle;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a behavioural uart, and a
// packet-level round-robin model of the expected byte and grant sequences.

module tb_uart_tx_arbiter;

    localparam int N      = 4;
    localparam int BT     = 16;
    localparam int LT     = 100;
    localparam int TX_CYC = 8;

    logic             clk_50m = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic [7:0]       uart_din;
    logic             uart_wr_en;
    logic             uart_tx_busy = 1'b0;
    logic [N-1:0]     grant;
    logic             lock_active;
    logic             err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (BT),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (uart_tx_busy),
        .grant        (grant),
        .lock_active  (lock_active),
        .err_timeout  (err_timeout)
    );

    always #10 clk_50m = ~clk_50m;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endfunction

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    // Requesters: each queue entry is {last, data}; valid follows queue occupancy.
    logic [8:0] src_q [N][$];
    int         valid_rise [N];

    always @(negedge clk_50m) begin
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                if (!req_valid[i]) valid_rise[i] = cyc;
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = h[7:0];
                req_last[i]         = h[8];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    always @(posedge clk_50m) begin
        for (int i = 0; i < N; i++)
            if (req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end

    // Behavioural uart: busy for TX_CYC cycles after accepting a strobe, then delivers.
    logic       uart_dead = 1'b0;
    int         u_cnt = 0;
    logic [7:0] u_shift = 8'h00;
    logic [7:0] rx_q [$];

    always @(posedge clk_50m) begin
        if (u_cnt != 0) begin
            if (u_cnt == 1) begin
                uart_tx_busy <= 1'b0;
                rx_q.push_back(u_shift);
            end
            u_cnt <= u_cnt - 1;
        end else if (uart_wr_en && !uart_dead) begin
            u_shift      <= uart_din;
            uart_tx_busy <= 1'b1;
            u_cnt        <= TX_CYC;
        end
    end

    // Expected sequences and event logs.
    logic [7:0] exp_bytes [$];
    int         exp_grants [$];
    int         wr_q [$];
    int         fall_q [$];
    int         err_q [$];
    int         gr_q [$];
    int         ready_cnt [N];

    logic [N-1:0] prev_g = '0;
    logic         prev_wr = 1'b0;
    logic         prev_busy = 1'b0;
    logic         prev_err = 1'b0;

    always @(negedge clk_50m) begin
        logic [7:0] b;
        int         gi;
        chk("grant_onehot", int'($countones(grant) <= 1), 1);
        chk("lock_vs_grant", int'(lock_active), int'(grant != '0));
        chk("ready_outside_grant", int'(req_ready & ~grant), 0);
        chk("ready_without_valid", int'(req_ready & ~req_valid), 0);
        chk("wr_en_two_cycles", int'(prev_wr && uart_wr_en), 0);
        chk("wr_en_while_busy", int'(uart_wr_en && uart_tx_busy), 0);
        chk("err_two_cycles", int'(prev_err && err_timeout), 0);
        if (uart_wr_en && !prev_wr) wr_q.push_back(cyc);
        if (prev_busy && !uart_tx_busy) fall_q.push_back(cyc);
        if (err_timeout && !prev_err) err_q.push_back(cyc);
        for (int i = 0; i < N; i++) ready_cnt[i] += int'(req_ready[i]);
        if (grant != '0 && grant != prev_g) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (grant[i]) gi = i;
            gr_q.push_back(cyc);
            if (exp_grants.size() == 0) chk("grant_unexpected", gi, -1);
            else chk("grant_order", gi, exp_grants.pop_front());
        end
        while (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            if (exp_bytes.size() == 0) chk("byte_unexpected", int'(b), -1);
            else chk("byte_order", int'(b), int'(exp_bytes.pop_front()));
        end
        prev_g    = grant;
        prev_wr   = uart_wr_en;
        prev_busy = uart_tx_busy;
        prev_err  = err_timeout;
    end

    function automatic logic [7:0] byte_of(input int i, input int p, input int b);
        return 8'(128 + 16 * i + 2 * p + b);
    endfunction

    // Packet-level round robin: every requester has all its packets pending from the start.
    task automatic rr_model(input int start, input int pk_per_req);
        int left [N];
        int ptr;
        int sel;
        ptr = start;
        for (int i = 0; i < N; i++) left[i] = pk_per_req;
        for (int n = 0; n < N * pk_per_req; n++) begin
            sel = -1;
            for (int k = N - 1; k >= 0; k--) if (left[(ptr + k) % N] > 0) sel = (ptr + k) % N;
            exp_grants.push_back(sel);
            for (int b = 0; b < 2; b++) exp_bytes.push_back(byte_of(sel, pk_per_req - left[sel], b));
            left[sel]--;
            ptr = (sel + 1) % N;
        end
    endtask

    function automatic bit drained();
        bit e = (exp_bytes.size() == 0) && (exp_grants.size() == 0) && (rx_q.size() == 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e && (grant == '0) && !uart_tx_busy;
    endfunction

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while (n < max_cyc && !drained()) begin
            @(negedge clk_50m);
            n++;
        end
        chk({tag, "_drain_timeout"}, int'(n >= max_cyc), 0);
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input string tag, input int max_cyc);
        int n = 0;
        while (n < max_cyc && grant != g) begin
            @(negedge clk_50m);
            n++;
        end
        chk({tag, "_grant_timeout"}, int'(n >= max_cyc), 0);
    endtask

    task automatic wait_err(input string tag, input int max_cyc);
        int n = 0;
        while (n < max_cyc && !err_timeout) begin
            @(negedge clk_50m);
            n++;
        end
        chk({tag, "_err_wait_timeout"}, int'(n >= max_cyc), 0);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        fall_q.delete();
        err_q.delete();
        gr_q.delete();
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    endtask

    function automatic int at(input int v, input bit ok);
        return ok ? v : -100000;
    endfunction

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #4;
        chk("rst_grant", int'(grant), 0);
        chk("rst_lock", int'(lock_active), 0);
        chk("rst_wr_en", int'(uart_wr_en), 0);
        chk("rst_din", int'(uart_din), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_err", int'(err_timeout), 0);
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst = 1'b0;

        // Single byte from requester 1; leaves rr_ptr at 2
        clear_logs();
        exp_grants.push_back(1);
        exp_bytes.push_back(8'hA5);
        src_q[1].push_back({1'b1, 8'hA5});
        wait_drain("single", 200);
        chk("single_wr_count", wr_q.size(), 1);
        chk("single_latency", at(wr_q.size() > 0 ? wr_q[0] - valid_rise[1] : 0, wr_q.size() > 0), 2);
        chk("single_ready_pulses", ready_cnt[1], 1);
        chk("single_no_err", err_q.size(), 0);

        // rr_ptr=2: simultaneous 0 and 3 -> 3 wins (search 2,3,0)
        clear_logs();
        exp_grants.push_back(3);
        exp_grants.push_back(0);
        exp_bytes.push_back(8'h03);
        exp_bytes.push_back(8'h01);
        src_q[0].push_back({1'b1, 8'h01});
        src_q[3].push_back({1'b1, 8'h03});
        wait_drain("ptr", 300);

        // Packet lock: req 2 arrives while req 0 owns a 3-byte packet
        clear_logs();
        exp_grants.push_back(0);
        exp_grants.push_back(2);
        exp_bytes.push_back(8'h10);
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h12);
        exp_bytes.push_back(8'h20);
        src_q[0].push_back({1'b0, 8'h10});
        src_q[0].push_back({1'b0, 8'h11});
        src_q[0].push_back({1'b1, 8'h12});
        wait_grant(4'b0001, "lock", 50);
        src_q[2].push_back({1'b1, 8'h20});
        wait_drain("lock", 500);
        chk("lock_wr_count", wr_q.size(), 4);
        chk("lock_gap1", at(wr_q.size() > 1 && fall_q.size() > 0 ? wr_q[1] - fall_q[0] : 0,
                            wr_q.size() > 1 && fall_q.size() > 0), 3);
        chk("lock_gap2", at(wr_q.size() > 2 && fall_q.size() > 1 ? wr_q[2] - fall_q[1] : 0,
                            wr_q.size() > 2 && fall_q.size() > 1), 3);
        // grant[2] two edges after the last byte of req 0 stops shifting
        chk("lock_grant2_after_last", at(gr_q.size() > 1 && fall_q.size() > 2 ?
                                         gr_q[1] - fall_q[2] : 0,
                                         gr_q.size() > 1 && fall_q.size() > 2), 2);

        // Reset while in WAIT_DONE; the uart keeps shifting its byte
        clear_logs();
        exp_grants.push_back(1);
        exp_bytes.push_back(8'h77);
        src_q[1].push_back({1'b1, 8'h77});
        begin
            int n = 0;
            while (n < 50 && !(uart_tx_busy && grant == 4'b0010)) begin
                @(negedge clk_50m);
                n++;
            end
            chk("reset_reach_busy_timeout", int'(n >= 50), 0);
        end
        @(negedge clk_50m);
        chk("pre_reset_lock", int'(lock_active), 1);
        chk("pre_reset_din", int'(uart_din), 8'h77);
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_grant", int'(grant), 0);
        chk("mid_reset_lock", int'(lock_active), 0);
        chk("mid_reset_din", int'(uart_din), 0);
        chk("mid_reset_wr_en", int'(uart_wr_en), 0);
        chk("mid_reset_ready", int'(req_ready), 0);
        chk("mid_reset_err", int'(err_timeout), 0);
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst = 1'b0;
        wait_drain("reset", 100);

        // Round robin after reset: 2 packets of 2 bytes per requester, all pending
        clear_logs();
        rr_model(0, 2);
        chk("model_g0", exp_grants[0], 0);
        chk("model_g1", exp_grants[1], 1);
        chk("model_g3", exp_grants[3], 3);
        chk("model_g4", exp_grants[4], 0);
        chk("model_b0", int'(exp_bytes[0]), 8'h80);
        chk("model_b2", int'(exp_bytes[2]), 8'h90);
        chk("model_b8", int'(exp_bytes[8]), 8'h82);
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 2; b++)
                    src_q[i].push_back({b == 1, byte_of(i, p, b)});
        wait_drain("rr", 3000);
        chk("rr_grant_count", gr_q.size(), 8);
        chk("rr_wr_count", wr_q.size(), 16);

        // Busy timeout: uart never answers; rr_ptr moves to 2, then 0 is served
        clear_logs();
        exp_grants.push_back(1);
        exp_grants.push_back(2);
        exp_grants.push_back(0);
        exp_bytes.push_back(8'h66);
        exp_bytes.push_back(8'h0A);
        uart_dead = 1'b1;
        src_q[1].push_back({1'b1, 8'h55});
        wait_grant(4'b0010, "busy", 50);
        src_q[0].push_back({1'b1, 8'h0A});
        src_q[2].push_back({1'b1, 8'h66});
        wait_err("busy", 100);
        chk("busy_err_lock", int'(lock_active), 0);
        chk("busy_err_grant", int'(grant), 0);
        uart_dead = 1'b0;
        wait_drain("busy", 300);
        chk("busy_err_count", err_q.size(), 1);
        chk("busy_err_delay", at(err_q.size() > 0 && wr_q.size() > 0 ? err_q[0] - wr_q[0] : 0,
                                 err_q.size() > 0 && wr_q.size() > 0), 17);

        // Lock timeout: req 3 stalls mid-packet, pending req 0 served after expiry
        clear_logs();
        exp_grants.push_back(3);
        exp_grants.push_back(0);
        exp_bytes.push_back(8'h30);
        exp_bytes.push_back(8'h40);
        src_q[3].push_back({1'b0, 8'h30});
        wait_grant(4'b1000, "hold", 50);
        src_q[0].push_back({1'b1, 8'h40});
        wait_err("hold", 400);
        chk("hold_err_lock", int'(lock_active), 0);
        chk("hold_err_grant", int'(grant), 0);
        wait_drain("hold", 200);
        chk("hold_err_count", err_q.size(), 1);
        // HOLD is entered one edge after tx_busy falls, expiry LT edges later
        chk("hold_err_delay", at(err_q.size() > 0 && fall_q.size() > 0 ? err_q[0] - fall_q[0] : 0,
                                 err_q.size() > 0 && fall_q.size() > 0), LT + 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart transmitter (din/wr_en/tx_busy) among NUM_REQ byte-stream requesters.
- Round-robin arbitration with packet locking: once granted, a requester keeps the transmitter until its byte flagged last has finished shifting out.
- Sits between on-chip message sources (status reporter, debug dump, loopback echo) and the uart instance, all in the clk_50m domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, max clk_50m cycles from wr_en pulse to tx_busy rising before abort.
- LOCK_TIMEOUT, 65535, max clk_50m cycles a locked requester may leave valid low mid-packet before the lock is released.

Ports:
- clk_50m  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
- req_last  in  NUM_REQ  byte is final byte of packet
- req_ready  out  NUM_REQ  byte accepted (one-cycle pulse)
- uart_din  out  8  to uart din, registered
- uart_wr_en  out  1  to uart wr_en, registered one-cycle pulse
- uart_tx_busy  in  1  from uart tx_busy
- grant  out  NUM_REQ  one-hot current owner, 0 when none
- lock_active  out  1  packet in progress
- err_timeout  out  1  one-cycle pulse on BUSY_TIMEOUT or LOCK_TIMEOUT expiry

Behaviour:
- Reset (async, immediate): state IDLE; uart_din=0, uart_wr_en=0, req_ready=0, grant=0, lock_active=0, err_timeout=0, rr_ptr=0, counters=0. Reset mid-byte abandons the packet; the uart is not reset by this block.
- Requester rule: once req_valid[i]=1, data and last stay stable until req_ready[i]. Dropping valid without a handshake is legal only between bytes.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE: if any req_valid and uart_tx_busy=0, pick the first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. Register grant one-hot, set lock_active=1, go to LOAD. Otherwise stay.
- LOAD (1 cycle): req_ready[g]=1 combinationally. On the edge: uart_din<=data[g], uart_wr_en<=1, last_r<=last[g], busy counter cleared, go to WAIT_BUSY.
- WAIT_BUSY: uart_wr_en is 0 from the second cycle on, so it is exactly one cycle high. If tx_busy=1, go to WAIT_DONE. Else increment the counter. At count==BUSY_TIMEOUT, pulse err_timeout, clear grant and lock, set rr_ptr=g+1, go to IDLE.
- WAIT_DONE: uart_din held. When tx_busy=0:
  - if last_r: clear grant and lock_active, set rr_ptr=(g+1) mod NUM_REQ, go to IDLE;
  - else go to HOLD with the lock counter cleared.
- HOLD: only requester g is considered; other requests are ignored.
  - If req_valid[g] go to LOAD.
  - Else increment the lock counter. At LOCK_TIMEOUT, pulse err_timeout, release as on last, go to IDLE.
- Latency: request in IDLE with tx_busy=0 → LOAD next cycle → uart_wr_en high the cycle after (2 cycles valid-to-wr_en). Back-to-back bytes within a packet: tx_busy fall → HOLD → LOAD → wr_en, 3 cycles gap.
- Fairness: rr_ptr advances only on packet end or abort, so a requester streaming multiple packets yields after each packet.
- Simultaneous events: requests for all indices at once grant rr_ptr first. A new request arriving during another's packet waits. req_valid and last on the same cycle as tx_busy fall are handled per the state rules above, with no lost byte.
- A single-byte packet (last=1 on first byte) releases the lock after that byte.
- grant is never multi-hot. req_ready is never asserted outside LOAD, or for a non-granted index.

Test Plan:
- Single byte: req_valid[1]=1, data=0xA5, last=1 → req_ready[1] pulses once; uart_wr_en is one cycle with din=0xA5, 2 cycles after valid; the bench uart model decodes 0xA5; grant returns to 0 and rr_ptr=2.
- Packet lock: req 0 sends {0x10,0x11,0x12(last)} while req 2 requests 0x20 → uart output is 10,11,12,20 in order; grant[2] asserts only after 0x12 completes.
- Round-robin: all four requesters hold 2-byte packets continuously for 8 packets → grant order 0,1,2,3,0,1,2,3; 16 bytes are received with no interleaving inside any packet.
- Busy timeout: tie uart_tx_busy=0 and request byte 0x55 → err_timeout pulses exactly 17 cycles after wr_en (BUSY_TIMEOUT=16); state returns to IDLE, grant=0, and the next requester is served.
- Lock timeout: LOCK_TIMEOUT=100; req 3 sends 0x30 (last=0) then drops valid → err_timeout pulses 100 cycles after entering HOLD; lock_active=0; pending req 0 is then granted.
- Reset mid-packet: assert rst while in WAIT_DONE → all outputs go to 0 immediately without a clock edge; after release, a fresh request is granted starting from index 0.
